// File: rtl/alu_op_a_fwd_stage_if.sv
// Request/response bus of the ALU operand-A forwarding stage.
// master: ID/EX side plus ALU consumer; slave: the stage itself.
interface alu_op_a_fwd_stage_if #(
   parameter int W     = 32,
   parameter int NFWD  = 2,
   parameter int CNT_W = 16
);
   logic                in_valid_i;
   logic                in_ready_o;
   logic [1:0]          op_a_sel_i;
   logic                imm_a_sel_i;
   logic [4:0]          rs1_addr_i;
   logic [W-1:0]        rf_rdata_a_i;
   logic [W-1:0]        pc_i;
   logic [W-1:0]        zimm_i;
   logic                lsu_addr_incr_req_i;
   logic [W-1:0]        lsu_addr_last_i;
   logic [NFWD-1:0]     fwd_valid_i;
   logic [NFWD*5-1:0]   fwd_addr_i;
   logic [NFWD*W-1:0]   fwd_data_i;
   logic [NFWD-1:0]     fwd_data_rdy_i;
   logic                out_valid_o;
   logic                out_ready_i;
   logic [W-1:0]        alu_operand_a_o;
   logic                fwd_hit_o;
   logic                stall_o;
   logic [CNT_W-1:0]    stall_cnt_o;

   modport master (
      output in_valid_i, op_a_sel_i, imm_a_sel_i, rs1_addr_i, rf_rdata_a_i,
             pc_i, zimm_i, lsu_addr_incr_req_i, lsu_addr_last_i,
             fwd_valid_i, fwd_addr_i, fwd_data_i, fwd_data_rdy_i, out_ready_i,
      input  in_ready_o, out_valid_o, alu_operand_a_o, fwd_hit_o, stall_o,
             stall_cnt_o
   );

   modport slave (
      input  in_valid_i, op_a_sel_i, imm_a_sel_i, rs1_addr_i, rf_rdata_a_i,
             pc_i, zimm_i, lsu_addr_incr_req_i, lsu_addr_last_i,
             fwd_valid_i, fwd_addr_i, fwd_data_i, fwd_data_rdy_i, out_ready_i,
      output in_ready_o, out_valid_o, alu_operand_a_o, fwd_hit_o, stall_o,
             stall_cnt_o
   );
endinterface

// File: rtl/alu_op_a_fwd_stage.sv
// ALU operand-A select with N-deep forwarding, load-use stall and a registered
// valid/ready output stage. Optional stall counter: ALU_OP_A_STALL_CNT_EN.
module alu_op_a_fwd_stage #(
   parameter int W     = 32,
   parameter int NFWD  = 2,
   parameter int CNT_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   alu_op_a_fwd_stage_if.slave bus
);
   localparam int IDX_W = (NFWD > 1) ? $clog2(NFWD) : 1;

   typedef enum logic [1:0] {
      SEL_REG_A  = 2'd0,
      SEL_FWD    = 2'd1,
      SEL_CURRPC = 2'd2,
      SEL_IMM    = 2'd3
   } op_a_sel_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   op_a_sel_e        eff_sel_s;
   logic [W-1:0]     imm_a_s;
   logic             hit_s;
   logic [IDX_W-1:0] win_s;
   logic             win_rdy_s;
   logic [W-1:0]     win_data_s;
   logic             reg_hit_s;
   logic             stall_s;
   logic             in_ready_s;
   logic             accept_s;
   logic [W-1:0]     operand_s;

   state_e           state_q, state_d;
   logic [W-1:0]     operand_q, operand_d;
   logic             fwd_hit_q, fwd_hit_d;

   // Operand source resolution and youngest-first forward match
   always_comb begin
      eff_sel_s = bus.lsu_addr_incr_req_i ? SEL_FWD : op_a_sel_e'(bus.op_a_sel_i);
      imm_a_s   = bus.imm_a_sel_i ? {W{1'b0}} : bus.zimm_i;
      hit_s     = 1'b0;
      win_s     = {IDX_W{1'b0}};
      // Walk oldest to youngest so the youngest match is written last
      for (int k = NFWD - 1; k >= 0; k--) begin
         if (bus.fwd_valid_i[k] && (bus.fwd_addr_i[5*k +: 5] == bus.rs1_addr_i) &&
             (bus.rs1_addr_i != 5'd0)) begin
            hit_s = 1'b1;
            win_s = IDX_W'(k);
         end else begin
            hit_s = hit_s;
            win_s = win_s;
         end
      end
      win_rdy_s  = bus.fwd_data_rdy_i[win_s];
      win_data_s = bus.fwd_data_i[win_s*W +: W];
      reg_hit_s  = (eff_sel_s == SEL_REG_A) && hit_s;
      stall_s    = bus.in_valid_i && reg_hit_s && !win_rdy_s;
      in_ready_s = !stall_s && ((state_q == ST_EMPTY) || bus.out_ready_i);
      accept_s   = bus.in_valid_i && in_ready_s && !flush_i;
      case (eff_sel_s)
         SEL_REG_A:  operand_s = hit_s ? win_data_s : bus.rf_rdata_a_i;
         SEL_FWD:    operand_s = bus.lsu_addr_last_i;
         SEL_CURRPC: operand_s = bus.pc_i;
         SEL_IMM:    operand_s = imm_a_s;
         default:    operand_s = bus.pc_i;
      endcase
   end

   // Output register next state; flush overrides load and drain
   always_comb begin
      state_d   = state_q;
      operand_d = operand_q;
      fwd_hit_d = fwd_hit_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else if (accept_s) begin
         state_d   = ST_FULL;
         operand_d = operand_s;
         fwd_hit_d = reg_hit_s;
      end else if ((state_q == ST_FULL) && bus.out_ready_i) begin
         state_d = ST_EMPTY;
      end else begin
         state_d = state_q;
      end
   end

   // Output stage state and registered operand
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_EMPTY;
         operand_q <= {W{1'b0}};
         fwd_hit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         operand_q <= operand_d;
         fwd_hit_q <= fwd_hit_d;
      end
   end

`ifdef ALU_OP_A_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating stall-cycle count; only reset clears it
   always_comb begin
      if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.stall_cnt_o = stall_cnt_q;
`else
   assign bus.stall_cnt_o = {CNT_W{1'b0}};
`endif

   assign bus.in_ready_o      = in_ready_s;
   assign bus.stall_o         = stall_s;
   assign bus.out_valid_o     = (state_q == ST_FULL);
   assign bus.alu_operand_a_o = operand_q;
   assign bus.fwd_hit_o       = fwd_hit_q;
endmodule
